wb_regfile_stage: RTL and testbench
===================================

// Module: wb_regfile_stage
// PURPOSE
//  Write-back stage directly downstream of the fetch/decode/execute stage.
//  Accepts execute results (data_out, destination register, write enable) through
//  a valid/ready handshake and buffers them in a 2-entry FIFO.
//  Drains one entry per cycle into a REG_N x DATA_W register file.
//  Provides two combinational read ports with forwarding from pending entries,
//  plus a registered commit pulse and a commit counter.
// PARAMETERS
//  DATA_W  32  width of result data and register file entries
//  REG_N   8   number of architectural registers (power of 2, >=2); reg 0 reads zero
//  ADDR_W  3   register index width, must equal log2(REG_N)
// PORTS
//  CLK           in   1       clock, rising-edge
//  reset         in   1       asynchronous, active-low reset
//  in_valid      in   1       execute result valid
//  in_ready      out  1       stage can accept (FIFO not full)
//  in_rd         in   ADDR_W  destination register index
//  in_we         in   1       1 = result writes register file
//  in_data       in   DATA_W  execute result (data_out of upstream stage)
//  wb_hold       in   1       1 = register file write port blocked, no drain this cycle
//  rd_addr_a/b   in   ADDR_W  read port A/B index
//  rd_data_a/b   out  DATA_W  read port A/B data (combinational)
//  wb_valid      out  1       registered 1-cycle pulse per drained entry
//  wb_rd         out  ADDR_W  index of the drained entry
//  wb_data       out  DATA_W  data of the drained entry
//  commit_count  out  16      drained-entry count, wraps 0xFFFF -> 0
// BEHAVIOUR
//  Reset (reset=0, async): FIFO emptied, all regs=0, wb_valid=0, wb_rd=0,
//   wb_data=0, commit_count=0. in_ready=1 after release.
//   Pending entries at reset are discarded and never written.
//  Accept: on a CLK edge with in_valid && in_ready, push {in_rd, in_we, in_data}.
//  in_ready = (count != 2); purely from the registered count, no pass-through when full.
//  Drain: on a CLK edge with count != 0 && !wb_hold, pop the oldest entry.
//   If we && rd != 0, write regs[rd]; otherwise the array is unchanged.
//   The next cycle: wb_valid=1, wb_rd/wb_data = popped entry, commit_count += 1.
//   A we=0 entry still drains, pulses wb_valid, and counts.
//  Same-edge push and pop: count unchanged, order preserved, FIFO pointers wrap mod 2.
//  Latency: accepted at edge N into an empty FIFO with wb_hold=0 -> written at
//   edge N+1; wb_valid high during the cycle after edge N+1.
//  wb_hold=1: no pop, no array write, wb_valid=0, count can rise to 2, then in_ready=0.
//  Read ports (A and B identical):
//   addr 0 -> 0.
//   Else youngest pending entry with we=1 and rd==addr -> its data.
//   Else regs[addr].
//   Values not yet in the FIFO (in_data this cycle) are not forwarded.
//  Reg 0 is never written and is always 0.
// TESTING
//  T1 reset: reset=0 mid-run with 2 pending -> count 0, in_ready=1, regs all 0,
//     wb_valid=0, pending writes lost.
//  T2 basic: push rd=3 we=1 data=100 -> next cycle wb_valid=1 wb_rd=3 wb_data=100;
//     rd_data_a(3)=100; commit_count=1.
//  T3 full/hold: wb_hold=1, push 200 then 300 -> in_ready=0 after 2nd push,
//     3rd push (400) ignored; release hold -> 200 then 300 drain in order.
//  T4 forward: hold, push rd=5 data=400 then rd=5 data=500 -> rd_data_b(5)=500
//     before any drain; after drains regs[5]=500.
//  T5 reg0/we=0: push rd=0 data=7 we=1 and rd=2 data=9 we=0 -> reads 0 and old
//     value; wb_valid pulses twice, commit_count +2.
//  T6 wrap: preload commit_count 0xFFFF via 65535 drains, drain one more -> 0x0000.

Source files
------------

// File: rtl/wb_regfile_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : wb_regfile_stage
// Brief   : Write-back stage, 2-entry result FIFO draining into a register file.
// Revision: 1.0
// ---------------------------------------------------------------------------
module wb_regfile_stage #(
   parameter int DATA_W = 32,
   parameter int REG_N  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic              in_we,
   input  logic [DATA_W-1:0] in_data,
   input  logic              wb_hold,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   output logic              wb_valid,
   output logic [ADDR_W-1:0] wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic [15:0]       commit_count
);

   localparam logic [1:0] c_EMPTY = 2'd0;
   localparam logic [1:0] c_FULL  = 2'd2;

   logic [ADDR_W-1:0] r_ent_rd   [2];
   logic              r_ent_we   [2];
   logic [DATA_W-1:0] r_ent_data [2];
   logic              r_wptr;
   logic              r_rptr;
   logic [1:0]        r_count;
   logic [DATA_W-1:0] r_regs [REG_N];

   logic              r_wb_valid;
   logic [ADDR_W-1:0] r_wb_rd;
   logic [DATA_W-1:0] r_wb_data;
   logic [15:0]       r_commit_count;

   logic              w_push;
   logic              w_pop;
   logic              w_young;

   assign in_ready = (r_count != c_FULL);
   assign w_push   = in_valid && in_ready;
   assign w_pop    = (r_count != c_EMPTY) && !wb_hold;
   // Slot just behind the write pointer holds the most recently accepted entry.
   assign w_young  = ~r_wptr;

   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_ent_rd[r_wptr]   <= in_rd;
         r_ent_we[r_wptr]   <= in_we;
         r_ent_data[r_wptr] <= in_data;
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_wptr         <= 1'b0;
         r_rptr         <= 1'b0;
         r_count        <= c_EMPTY;
         r_wb_valid     <= 1'b0;
         r_wb_rd        <= '0;
         r_wb_data      <= '0;
         r_commit_count <= 16'd0;
         for (int i = 0; i < REG_N; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_wptr <= ~r_wptr;
         end
         if (w_pop) begin
            r_rptr <= ~r_rptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
         r_wb_valid <= w_pop;
         if (w_pop) begin
            r_wb_rd        <= r_ent_rd[r_rptr];
            r_wb_data      <= r_ent_data[r_rptr];
            r_commit_count <= r_commit_count + 16'd1;
            if (r_ent_we[r_rptr] && (r_ent_rd[r_rptr] != '0)) begin
               r_regs[r_ent_rd[r_rptr]] <= r_ent_data[r_rptr];
            end
         end
      end
   end

   // Youngest matching pending write wins over the older one and the array.
   function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] addr);
      logic [DATA_W-1:0] v_data;
      v_data = r_regs[addr];
      if ((r_count == c_FULL) && r_ent_we[r_rptr] && (r_ent_rd[r_rptr] == addr)) begin
         v_data = r_ent_data[r_rptr];
      end
      if ((r_count != c_EMPTY) && r_ent_we[w_young] && (r_ent_rd[w_young] == addr)) begin
         v_data = r_ent_data[w_young];
      end
      if (addr == '0) begin
         v_data = '0;
      end
      return v_data;
   endfunction

   assign rd_data_a    = f_read(rd_addr_a);
   assign rd_data_b    = f_read(rd_addr_b);
   assign wb_valid     = r_wb_valid;
   assign wb_rd        = r_wb_rd;
   assign wb_data      = r_wb_data;
   assign commit_count = r_commit_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_wb_regfile_stage
// Brief   : Self-checking bench for wb_regfile_stage (vector table + scoreboard).
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_wb_regfile_stage;

   logic        CLK = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_rd = 3'd0;
   logic        in_we = 1'b0;
   logic [31:0] in_data = 32'd0;
   logic        wb_hold = 1'b0;
   logic [2:0]  rd_addr_a = 3'd0;
   logic [2:0]  rd_addr_b = 3'd0;
   logic [31:0] rd_data_a;
   logic [31:0] rd_data_b;
   logic        wb_valid;
   logic [2:0]  wb_rd;
   logic [31:0] wb_data;
   logic [15:0] commit_count;

   wb_regfile_stage #(.DATA_W(32), .REG_N(8), .ADDR_W(3)) dut (
      .CLK(CLK), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_we(in_we),
      .in_data(in_data), .wb_hold(wb_hold),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .commit_count(commit_count)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [2:0]  rd;
      logic        we;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      logic [2:0]  rd;
      logic        we;
      logic [31:0] data;
      logic [2:0]  ra;
      logic [31:0] ea;
      logic [2:0]  rb;
      logic [31:0] eb;
   } vec_t;

   exp_t        sb_q[$];
   vec_t        vecs[6];
   int          n_tests = 0;
   int          n_fail = 0;
   int          pulses = 0;
   logic [15:0] exp_commit = 16'd0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Scoreboard: record accepted results, compare each write-back pulse.
   always @(negedge CLK) begin
      exp_t e;
      if (reset) begin
         if (wb_valid) begin
            if (sb_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL wb_unexpected: got wb_valid=1 rd=%0d data=%h, required no pulse", wb_rd, wb_data);
            end else begin
               e = sb_q.pop_front();
               check("wb_rd", 64'(wb_rd), 64'(e.rd));
               check("wb_data", 64'(wb_data), 64'(e.data));
               exp_commit = exp_commit + 16'd1;
               pulses++;
            end
         end
         if (in_valid && in_ready) begin
            e.rd = in_rd;
            e.we = in_we;
            e.data = in_data;
            sb_q.push_back(e);
         end
      end
   end

   task automatic push(input logic [2:0] rd, input logic we, input logic [31:0] data);
      int n = 0;
      @(posedge CLK); #1;
      in_valid = 1'b1; in_rd = rd; in_we = we; in_data = data;
      while (!in_ready && n < 20) begin
         @(posedge CLK); #1;
         n++;
      end
      if (!in_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL push_timeout: got in_ready=0 required 1");
      end
      @(posedge CLK); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      do begin
         @(negedge CLK); #1;
         n++;
      end while (sb_q.size() != 0 && n < 20);
      if (sb_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d pending required 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] ea,
                         input logic [2:0] b, input logic [31:0] eb);
      rd_addr_a = a;
      rd_addr_b = b;
      #1;
      check({name, "_a"}, 64'(rd_data_a), 64'(ea));
      check({name, "_b"}, 64'(rd_data_b), 64'(eb));
   endtask

   initial begin
      int snap;
      logic [15:0] csnap;

      vecs[0] = '{3'd1, 1'b1, 32'd11,         3'd1, 32'd11,         3'd3, 32'd100};
      vecs[1] = '{3'd0, 1'b1, 32'd7,          3'd0, 32'd0,          3'd1, 32'd11};
      vecs[2] = '{3'd2, 1'b0, 32'd9,          3'd2, 32'd0,          3'd2, 32'd0};
      vecs[3] = '{3'd7, 1'b1, 32'hDEADBEEF,   3'd7, 32'hDEADBEEF,   3'd6, 32'd0};
      vecs[4] = '{3'd3, 1'b1, 32'd101,        3'd3, 32'd101,        3'd7, 32'hDEADBEEF};
      vecs[5] = '{3'd6, 1'b1, 32'hFFFFFFFF,   3'd6, 32'hFFFFFFFF,   3'd1, 32'd11};

      // Reset state
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_wb_valid", 64'(wb_valid), 64'd0);
      check("rst_commit", 64'(commit_count), 64'd0);
      check("rst_wb_data", 64'(wb_data), 64'd0);
      repeat (2) @(negedge CLK);
      reset = 1'b1;

      // T2 basic: one write, check one-cycle write-back latency
      push(3'd3, 1'b1, 32'd100);
      @(negedge CLK); #1;
      check("t2_wb_early", 64'(wb_valid), 64'd0);
      rd_chk("t2_fwd", 3'd3, 32'd100, 3'd3, 32'd100);
      @(negedge CLK); #1;
      check("t2_wb_valid", 64'(wb_valid), 64'd1);
      check("t2_wb_rd", 64'(wb_rd), 64'd3);
      check("t2_wb_data", 64'(wb_data), 64'd100);
      check("t2_commit", 64'(commit_count), 64'd1);
      rd_chk("t2_reg", 3'd3, 32'd100, 3'd0, 32'd0);
      @(negedge CLK); #1;
      check("t2_wb_pulse_end", 64'(wb_valid), 64'd0);

      // Vector table
      for (int i = 0; i < 6; i++) begin
         push(vecs[i].rd, vecs[i].we, vecs[i].data);
         wait_drain();
         rd_chk($sformatf("vec%0d", i), vecs[i].ra, vecs[i].ea, vecs[i].rb, vecs[i].eb);
      end
      check("vec_commit", 64'(commit_count), 64'd7);

      // T3 full / hold
      csnap = commit_count;
      wb_hold = 1'b1;
      push(3'd4, 1'b1, 32'd200);
      push(3'd6, 1'b1, 32'd300);
      @(negedge CLK); #1;
      check("t3_in_ready_full", 64'(in_ready), 64'd0);
      check("t3_wb_held", 64'(wb_valid), 64'd0);
      rd_chk("t3_fwd", 3'd4, 32'd200, 3'd6, 32'd300);
      @(posedge CLK); #1;
      in_valid = 1'b1; in_rd = 3'd4; in_we = 1'b1; in_data = 32'd400;
      @(posedge CLK); #1;
      in_valid = 1'b0;
      wb_hold = 1'b0;
      wait_drain();
      repeat (2) @(negedge CLK); #1;
      rd_chk("t3_regs", 3'd4, 32'd200, 3'd6, 32'd300);
      check("t3_commit", 64'(commit_count), 64'(csnap + 16'd2));

      // T4 forwarding from pending entries
      wb_hold = 1'b1;
      push(3'd5, 1'b1, 32'd400);
      @(negedge CLK); #1;
      rd_chk("t4_fwd1", 3'd5, 32'd400, 3'd5, 32'd400);
      @(posedge CLK); #1;
      in_valid = 1'b1; in_rd = 3'd5; in_we = 1'b1; in_data = 32'd500;
      @(negedge CLK); #1;
      rd_chk("t4_no_passthru", 3'd5, 32'd400, 3'd5, 32'd400);
      @(posedge CLK); #1;
      in_valid = 1'b0;
      @(negedge CLK); #1;
      rd_chk("t4_fwd2", 3'd4, 32'd200, 3'd5, 32'd500);
      wb_hold = 1'b0;
      wait_drain();
      rd_chk("t4_reg", 3'd5, 32'd500, 3'd5, 32'd500);

      // T5 reg0 and we=0 entries
      push(3'd2, 1'b1, 32'd33);
      wait_drain();
      snap = pulses;
      csnap = commit_count;
      push(3'd0, 1'b1, 32'd7);
      push(3'd2, 1'b0, 32'd9);
      wait_drain();
      rd_chk("t5_regs", 3'd0, 32'd0, 3'd2, 32'd33);
      check("t5_pulses", 64'(pulses - snap), 64'd2);
      check("t5_commit", 64'(commit_count), 64'(csnap + 16'd2));

      // T1 reset mid-run with two pending writes
      wb_hold = 1'b1;
      push(3'd1, 1'b1, 32'd77);
      push(3'd3, 1'b1, 32'd88);
      @(negedge CLK); #2;
      reset = 1'b0;
      #1;
      sb_q.delete();
      exp_commit = 16'd0;
      check("t1_in_ready", 64'(in_ready), 64'd1);
      check("t1_wb_valid", 64'(wb_valid), 64'd0);
      check("t1_commit", 64'(commit_count), 64'd0);
      for (int a = 1; a < 8; a++) begin
         rd_chk($sformatf("t1_reg%0d", a), 3'(a), 32'd0, 3'(a), 32'd0);
      end
      @(negedge CLK);
      reset = 1'b1;
      wb_hold = 1'b0;
      snap = pulses;
      repeat (4) @(negedge CLK);
      #1;
      check("t1_no_drain", 64'(pulses - snap), 64'd0);
      rd_chk("t1_lost", 3'd1, 32'd0, 3'd3, 32'd0);

      // T6 commit counter wrap
      @(posedge CLK); #1;
      in_valid = 1'b1; in_rd = 3'd1; in_we = 1'b1;
      for (int i = 0; i < 65535; i++) begin
         in_data = i;
         @(posedge CLK); #1;
      end
      in_valid = 1'b0;
      wait_drain();
      check("t6_commit_max", 64'(commit_count), 64'hFFFF);
      check("t6_model_max", 64'(commit_count), 64'(exp_commit));
      push(3'd2, 1'b1, 32'd42);
      wait_drain();
      check("t6_commit_wrap", 64'(commit_count), 64'd0);
      rd_chk("t6_regs", 3'd1, 32'd65534, 3'd2, 32'd42);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
